// File: rtl/ad9783_cfg_sequencer.sv
// AD9783 configuration sequencer: DAC reset, power-up register table, then
// round-robin arbitration of two host requesters onto one SPI command port.
module ad9783_cfg_sequencer #(
  parameter int RST_CYCLES = 16,
  parameter int TIMEOUT    = 1023
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic        dac_rst_out,
  output logic        init_done_out,
  output logic        cmd_trig_out,
  output logic [15:0] cmd_addr_out,
  output logic [15:0] cmd_data_out,
  input  logic        cmd_done_in,
  input  logic [15:0] cmd_rdata_in,
  input  logic        req0_in,
  input  logic [15:0] req0_addr_in,
  input  logic [15:0] req0_data_in,
  output logic        ack0_out,
  input  logic        req1_in,
  input  logic [15:0] req1_addr_in,
  input  logic [15:0] req1_data_in,
  output logic        ack1_out,
  output logic [15:0] rdata_out,
  output logic        err_out
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    DACRST,
    INIT_ISSUE,
    INIT_WAIT,
    IDLE,
    HOST_ISSUE,
    HOST_WAIT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [RW-1:0] rst_cnt;
  logic [TW-1:0] wait_cnt;
  logic [1:0]    init_idx;
  logic [1:0]    load_idx;
  logic [31:0]   init_entry;
  logic          rr_ptr;
  logic          grant_id;
  logic          grant_nxt;
  logic          pend0;
  logic          pend1;
  logic          in_wait;
  logic          txn_end;
  logic          timed_out;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= DACRST;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // a requester whose ack is on the wire this cycle has not yet had a chance to drop its request
    pend0     = req0_in & ~ack0_out;
    pend1     = req1_in & ~ack1_out;
    in_wait   = (state == INIT_WAIT) || (state == HOST_WAIT);
    txn_end   = in_wait && (cmd_done_in || (wait_cnt == WAIT_LAST));
    timed_out = in_wait && !cmd_done_in && (wait_cnt == WAIT_LAST);
    load_idx  = (state == INIT_WAIT) ? (init_idx + 2'd1) : init_idx;
    case (load_idx)
      2'd0:    init_entry = {16'h0000, 16'h0000};
      2'd1:    init_entry = {16'h0002, 16'h0000};
      2'd2:    init_entry = {16'h0003, 16'h0000};
      default: init_entry = {16'h0004, 16'h00C0};
    endcase

    state_nxt = state;
    grant_nxt = grant_id;
    case (state)
      DACRST: begin
        if (rst_cnt == RST_LAST) begin
          state_nxt = INIT_ISSUE;
        end
      end
      INIT_ISSUE: state_nxt = INIT_WAIT;
      INIT_WAIT: begin
        if (txn_end) begin
          state_nxt = (init_idx == 2'd3) ? IDLE : INIT_ISSUE;
        end
      end
      IDLE: begin
        if (pend0 || pend1) begin
          state_nxt = HOST_ISSUE;
          grant_nxt = (pend0 && pend1) ? rr_ptr : pend1;
        end
      end
      HOST_ISSUE: state_nxt = HOST_WAIT;
      HOST_WAIT: begin
        if (txn_end) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = DACRST;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      dac_rst_out   <= 1'b1;
      init_done_out <= 1'b0;
      cmd_trig_out  <= 1'b0;
      cmd_addr_out  <= '0;
      cmd_data_out  <= '0;
      ack0_out      <= 1'b0;
      ack1_out      <= 1'b0;
      rdata_out     <= '0;
      err_out       <= 1'b0;
      rst_cnt       <= '0;
      wait_cnt      <= '0;
      init_idx      <= '0;
      rr_ptr        <= 1'b0;
      grant_id      <= 1'b0;
    end else begin
      dac_rst_out  <= (state_nxt == DACRST);
      cmd_trig_out <= (state_nxt == INIT_ISSUE) || (state_nxt == HOST_ISSUE);
      ack0_out     <= 1'b0;
      ack1_out     <= 1'b0;
      rst_cnt      <= (state == DACRST) ? (rst_cnt + 1'b1) : '0;
      wait_cnt     <= in_wait ? (wait_cnt + 1'b1) : '0;

      if (timed_out) begin
        err_out <= 1'b1;
      end

      // the command bus is only reloaded on entry to an issue state, so it stays put through the wait
      if (state_nxt == INIT_ISSUE) begin
        {cmd_addr_out, cmd_data_out} <= init_entry;
      end

      if (state == INIT_WAIT && txn_end) begin
        if (init_idx == 2'd3) begin
          init_done_out <= 1'b1;
        end else begin
          init_idx <= init_idx + 2'd1;
        end
      end

      if (state == IDLE && state_nxt == HOST_ISSUE) begin
        grant_id     <= grant_nxt;
        rr_ptr       <= ~grant_nxt;
        cmd_addr_out <= grant_nxt ? req1_addr_in : req0_addr_in;
        cmd_data_out <= grant_nxt ? req1_data_in : req0_data_in;
      end

      if (state == HOST_WAIT && txn_end) begin
        rdata_out <= cmd_done_in ? cmd_rdata_in : 16'hFFFF;
        ack0_out  <= ~grant_id;
        ack1_out  <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_ad9783_cfg_sequencer.sv
// Scoreboard bench for ad9783_cfg_sequencer: directed stimulus pushes expected
// triggers/acks into queues; a negedge monitor pops and compares them.
module tb_ad9783_cfg_sequencer;

  localparam int RST_CYCLES = 16;
  localparam int TIMEOUT    = 1023;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        dac_rst_out;
  logic        init_done_out;
  logic        cmd_trig_out;
  logic [15:0] cmd_addr_out;
  logic [15:0] cmd_data_out;
  logic        cmd_done_in = 1'b0;
  logic [15:0] cmd_rdata_in = '0;
  logic        req0_in = 1'b0;
  logic [15:0] req0_addr_in = '0;
  logic [15:0] req0_data_in = '0;
  logic        ack0_out;
  logic        req1_in = 1'b0;
  logic [15:0] req1_addr_in = '0;
  logic [15:0] req1_data_in = '0;
  logic        ack1_out;
  logic [15:0] rdata_out;
  logic        err_out;

  logic [31:0] exp_trig[$];
  logic [16:0] exp_ack[$];
  logic [15:0] rsp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int trig_cyc = 0;
  int ack_cyc = 0;
  int rsp_cd = 0;
  int hold_left = 0;
  bit responder_en = 1'b0;

  ad9783_cfg_sequencer #(.RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .dac_rst_out(dac_rst_out), .init_done_out(init_done_out),
    .cmd_trig_out(cmd_trig_out), .cmd_addr_out(cmd_addr_out), .cmd_data_out(cmd_data_out),
    .cmd_done_in(cmd_done_in), .cmd_rdata_in(cmd_rdata_in),
    .req0_in(req0_in), .req0_addr_in(req0_addr_in), .req0_data_in(req0_data_in), .ack0_out(ack0_out),
    .req1_in(req1_in), .req1_addr_in(req1_addr_in), .req1_data_in(req1_data_in), .ack1_out(ack1_out),
    .rdata_out(rdata_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic flag_fail(input string name, input logic [31:0] actual);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: actual=0x%0h required=nothing pending", name, actual);
  endtask

  task automatic push_expect(input logic id, input logic [15:0] addr, input logic [15:0] data,
                             input logic [15:0] rdata, input bit respond);
    exp_trig.push_back({addr, data});
    exp_ack.push_back({id, rdata});
    if (respond) rsp_q.push_back(rdata);
  endtask

  task automatic set_req(input logic id, input logic [15:0] addr, input logic [15:0] data);
    if (id) begin
      req1_addr_in = addr; req1_data_in = data; req1_in = 1'b1;
    end else begin
      req0_addr_in = addr; req0_data_in = data; req0_in = 1'b1;
    end
  endtask

  task automatic apply_stimulus(input logic id, input logic [15:0] addr, input logic [15:0] data,
                                input logic [15:0] rdata, input bit respond);
    push_expect(id, addr, data, rdata, respond);
    set_req(id, addr, data);
  endtask

  task automatic push_init();
    exp_trig.push_back({16'h0000, 16'h0000});
    exp_trig.push_back({16'h0002, 16'h0000});
    exp_trig.push_back({16'h0003, 16'h0000});
    exp_trig.push_back({16'h0004, 16'h00C0});
    repeat (4) rsp_q.push_back(16'h0000);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_dac_rst"}, 32'(dac_rst_out), 32'd1);
    check_output({tag, "_init_done"}, 32'(init_done_out), 32'd0);
    check_output({tag, "_trig"}, 32'(cmd_trig_out), 32'd0);
    check_output({tag, "_addr"}, 32'(cmd_addr_out), 32'd0);
    check_output({tag, "_data"}, 32'(cmd_data_out), 32'd0);
    check_output({tag, "_acks"}, 32'({ack1_out, ack0_out}), 32'd0);
    check_output({tag, "_rdata"}, 32'(rdata_out), 32'd0);
    check_output({tag, "_err"}, 32'(err_out), 32'd0);
  endtask

  task automatic count_dac_rst(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!dac_rst_out) break;
      n++;
      @(negedge clk_in);
    end
  endtask

  task automatic wait_init(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_in);
      if (init_done_out) begin seen = 1'b1; break; end
    end
    check_output({name, "_init_done"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit drained = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      if (exp_trig.size() == 0 && exp_ack.size() == 0 && !req0_in && !req1_in) begin
        drained = 1'b1;
        break;
      end
    end
    if (!drained) flag_fail({"drain_", name}, 32'(exp_ack.size()));
    repeat (5) @(negedge clk_in);
  endtask

  // Scoreboard monitor: every trig and ack the DUT presents must match the head of its queue.
  always @(negedge clk_in) begin
    logic [31:0] et;
    logic [16:0] ea;
    if (rst_in) begin
      if (cmd_trig_out) begin
        trig_cyc = cyc;
        if (exp_trig.size() == 0) begin
          flag_fail("spurious_trig", {cmd_addr_out, cmd_data_out});
        end else begin
          et = exp_trig.pop_front();
          check_output("trig_addr", 32'(cmd_addr_out), 32'(et[31:16]));
          check_output("trig_data", 32'(cmd_data_out), 32'(et[15:0]));
        end
      end
      if (ack0_out || ack1_out) begin
        ack_cyc = cyc;
        check_output("ack_after_init", 32'(init_done_out), 32'd1);
        if (exp_ack.size() == 0) begin
          flag_fail("spurious_ack", 32'({ack1_out, ack0_out}));
        end else begin
          ea = exp_ack.pop_front();
          check_output("ack_id", 32'({ack1_out, ack0_out}), ea[16] ? 32'd2 : 32'd1);
          check_output("ack_rdata", 32'(rdata_out), 32'(ea[15:0]));
        end
      end
    end
  end

  // SPI responder: completion pulse three cycles after each trig.
  always @(negedge clk_in) begin
    cmd_done_in = 1'b0;
    if (!rst_in) begin
      rsp_cd = 0;
    end else begin
      if (rsp_cd > 0) begin
        rsp_cd--;
        if (rsp_cd == 0) begin
          cmd_done_in = 1'b1;
          cmd_rdata_in = (rsp_q.size() != 0) ? rsp_q.pop_front() : 16'h0000;
        end
      end
      if (cmd_trig_out && responder_en) rsp_cd = 3;
    end
  end

  // Requesters drop their request on ack, unless holding for a burst.
  always @(negedge clk_in) begin
    if (rst_in && (ack0_out || ack1_out)) begin
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) begin
          req0_in = 1'b0;
          req1_in = 1'b0;
        end
      end else begin
        if (ack0_out) req0_in = 1'b0;
        if (ack1_out) req1_in = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    bit seen;

    repeat (3) @(negedge clk_in);
    #2 check_reset_values("por");

    responder_en = 1'b1;
    push_init();
    @(negedge clk_in);
    rst_in = 1'b1;
    count_dac_rst(n);
    check_output("dac_rst_cycles", 32'(n), 32'(RST_CYCLES));
    wait_init("init1");
    check_output("init1_trigs_left", 32'(exp_trig.size()), 32'd0);
    check_output("init1_err", 32'(err_out), 32'd0);

    $display("[TB] simultaneous requests after init");
    apply_stimulus(1'b0, 16'h0005, 16'h1111, 16'h1234, 1'b1);
    apply_stimulus(1'b1, 16'h0006, 16'h2222, 16'hABCD, 1'b1);
    wait_idle("rr_pair", 200);
    check_output("trig_to_ack_cycles", 32'(ack_cyc - trig_cyc), 32'd4);
    check_output("rdata_hold", 32'(rdata_out), 32'h0000ABCD);

    $display("[TB] both requests held for four transactions");
    hold_left = 4;
    push_expect(1'b0, 16'h0020, 16'h0101, 16'h1111, 1'b1);
    push_expect(1'b1, 16'h0021, 16'h0202, 16'h2222, 1'b1);
    push_expect(1'b0, 16'h0020, 16'h0101, 16'h3333, 1'b1);
    push_expect(1'b1, 16'h0021, 16'h0202, 16'h4444, 1'b1);
    set_req(1'b0, 16'h0020, 16'h0101);
    set_req(1'b1, 16'h0021, 16'h0202);
    wait_idle("rr_hold", 400);

    $display("[TB] unanswered host command");
    responder_en = 1'b0;
    apply_stimulus(1'b1, 16'h0030, 16'h0303, 16'hFFFF, 1'b0);
    wait_idle("timeout", TIMEOUT + 200);
    check_output("timeout_trig_to_ack", 32'(ack_cyc - trig_cyc), 32'(TIMEOUT + 1));
    check_output("timeout_err", 32'(err_out), 32'd1);
    responder_en = 1'b1;
    apply_stimulus(1'b0, 16'h0007, 16'h0777, 16'h5555, 1'b1);
    wait_idle("after_timeout", 200);
    check_output("err_sticky", 32'(err_out), 32'd1);
    check_output("rdata_after_timeout", 32'(rdata_out), 32'h00005555);

    $display("[TB] reset during host wait");
    responder_en = 1'b0;
    apply_stimulus(1'b0, 16'h0009, 16'h0999, 16'hFFFF, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (exp_trig.size() == 0) begin seen = 1'b1; break; end
    end
    check_output("mid_wait_trig_seen", 32'(seen), 32'd1);
    repeat (2) @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1 check_reset_values("mid_wait");
    exp_ack.delete();
    rsp_q.delete();
    req0_in = 1'b0;
    repeat (3) @(negedge clk_in);

    $display("[TB] request during init replay");
    responder_en = 1'b1;
    push_init();
    rst_in = 1'b1;
    count_dac_rst(n);
    check_output("dac_rst_cycles_replay", 32'(n), 32'(RST_CYCLES));
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (exp_trig.size() <= 3) begin seen = 1'b1; break; end
      @(negedge clk_in);
    end
    check_output("replay_first_trig", 32'(seen), 32'd1);
    check_output("replay_init_done_low", 32'(init_done_out), 32'd0);
    apply_stimulus(1'b0, 16'h0010, 16'h5A5A, 16'h0BEE, 1'b1);
    wait_idle("req_during_init", 400);
    check_output("replay_init_done", 32'(init_done_out), 32'd1);
    check_output("replay_rdata", 32'(rdata_out), 32'h00000BEE);
    check_output("replay_err", 32'(err_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ad9783_cfg_sequencer.md
AD9783_CFG_SEQUENCER -- requirements
Module: ad9783_cfg_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles dac_rst_out is held high after reset release.
REQ-002 SHALL have parameter TIMEOUT, default 1023: maximum cycles to wait for cmd_done_in per transaction.
REQ-003 SHALL have ports clk_in (in, 1, 100 MHz system clock) and rst_in (in, 1, reset); one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports dac_rst_out (out, 1, DAC hardware reset) and init_done_out (out, 1, power-up table complete).
REQ-005 SHALL have ports cmd_trig_out (out, 1, one-cycle command strobe), cmd_addr_out (out, 16, SPI address), cmd_data_out (out, 16, SPI write data), cmd_done_in (in, 1, one-cycle completion pulse), and cmd_rdata_in (in, 16, read-back data valid with cmd_done_in).
REQ-006 SHALL have ports reqN_in (in, 1), reqN_addr_in (in, 16), reqN_data_in (in, 16), ackN_out (out, 1), rdata_out (out, 16), for requesters N = 0 and 1.
REQ-007 SHALL have port err_out (out, 1, sticky timeout flag).

Function
REQ-008 SHALL implement states DACRST, INIT_ISSUE, INIT_WAIT, IDLE, HOST_ISSUE, HOST_WAIT.
REQ-009 SHALL enter DACRST on reset and hold dac_rst_out=1 for exactly RST_CYCLES clocks after rst_in deasserts, then go to INIT_ISSUE with dac_rst_out=0.
REQ-010 SHALL hold a fixed 4-entry init table (addr,data): (0x0000,0x0000), (0x0002,0x0000), (0x0003,0x0000), (0x0004,0x00C0), issued in index order.
REQ-011 In INIT_ISSUE, SHALL drive cmd_addr_out/cmd_data_out from the current entry, pulse cmd_trig_out for one cycle, and go to INIT_WAIT next cycle.
REQ-012 In INIT_WAIT, on cmd_done_in, SHALL advance the index and return to INIT_ISSUE; after entry 3 completes, SHALL go to IDLE and set init_done_out=1 in the same cycle as IDLE entry.
REQ-013 cmd_addr_out/cmd_data_out SHALL remain stable from the cycle of cmd_trig_out until the cycle after cmd_done_in.
REQ-014 SHALL ignore reqN_in until init_done_out=1; requests are level-held by the requester until ackN_out.
REQ-015 In IDLE, SHALL grant one pending request per cycle, round-robin: on simultaneous req0_in and req1_in, grant the requester not granted last; after reset, requester 0 has priority.
REQ-016 On grant, SHALL latch the winner's addr/data, go to HOST_ISSUE, pulse cmd_trig_out the following cycle, then enter HOST_WAIT.
REQ-017 In HOST_WAIT, on cmd_done_in, SHALL register cmd_rdata_in into rdata_out, pulse the granted ackN_out for one cycle on the next clock, and return to IDLE.
REQ-018 rdata_out SHALL hold its value until the next completion.
REQ-019 SHALL count cycles in INIT_WAIT/HOST_WAIT; on reaching TIMEOUT without cmd_done_in, SHALL set err_out=1 and treat the transaction as complete (INIT: advance index; HOST: ack with rdata_out=0xFFFF).
REQ-020 SHALL ignore cmd_done_in outside the WAIT states.
REQ-021 cmd_done_in in the same cycle as cmd_trig_out SHALL NOT complete the transaction.
REQ-022 err_out SHALL clear only on reset.

Reset
REQ-023 Asserting rst_in at any time, including mid-transaction, SHALL immediately force state DACRST, dac_rst_out=1, init_done_out=0, cmd_trig_out=0, cmd_addr_out=0, cmd_data_out=0, ack0_out=ack1_out=0, rdata_out=0, err_out=0, init index 0, and round-robin pointer to requester 0.
REQ-024 After reset release, SHALL restart the full DACRST and init sequence.

Verification
REQ-025 Release reset, answer each trig with cmd_done_in 3 cycles later -> dac_rst_out high 16 cycles, then 4 trigs with addr 0x0000/0x0002/0x0003/0x0004, data 0x0000/0x0000/0x0000/0x00C0, then init_done_out=1.
REQ-026 After init, assert req0_in and req1_in together (addr 0x0005/0x0006), with cmd_rdata_in 0x1234 then 0xABCD -> trig addr 0x0005 first, ack0_out with rdata_out=0x1234, then addr 0x0006, ack1_out with rdata_out=0xABCD.
REQ-027 Hold both requests continuously for 4 transactions -> grants alternate 0,1,0,1.
REQ-028 Never drive cmd_done_in after a host trig -> ack after TIMEOUT cycles with rdata_out=0xFFFF and err_out=1, which stays set.
REQ-029 Assert rst_in during HOST_WAIT -> all outputs at reset values asynchronously, no ack is issued, and the init sequence replays from entry 0.
REQ-030 Assert req0_in during the init sequence -> no ack0_out until init_done_out=1, then exactly one ack0_out.
